// File: rtl/unpacker.sv
// Unpacker: captures a packed word of up to NUM_DATA elements and streams them out
// one per valid/ready transfer, highest occupied lane first.
module unpacker #(
    parameter int unsigned NUM_DATA   = 32,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             Load,
    input  logic [$clog2(NUM_DATA):0]        NumUnpack,
    input  logic [DATA_WIDTH*NUM_DATA-1:0]   DatIn,
    output logic                             RdyLoad,
    output logic                             ValOut,
    input  logic                             RdyOut,
    output logic [DATA_WIDTH-1:0]            DatOut,
    output logic                             LastOut,
    output logic                             Done
);

    localparam int unsigned CNT_W  = $clog2(NUM_DATA) + 1;
    localparam int unsigned LANE_W = (NUM_DATA > 1) ? $clog2(NUM_DATA) : 1;
    localparam int unsigned WORD_W = DATA_WIDTH * NUM_DATA;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_DATA);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FNH  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, neff;
    logic [WORD_W-1:0]      word_q, word_d;
    logic [LANE_W-1:0]      lane;
    logic [DATA_WIDTH-1:0]  dat_q, dat_d;
    logic                   val_q, val_d;
    logic                   last_q, last_d;
    logic                   done_q, done_d;
    logic                   rdy_load_q, rdy_load_d;

    // Next state, counter and the registered view of the element presented next cycle
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        neff       = (NumUnpack > MAX_CNT) ? MAX_CNT : NumUnpack;
        lane       = '0;
        dat_d      = dat_q;
        val_d      = 1'b0;
        last_d     = 1'b0;
        done_d     = 1'b0;
        rdy_load_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (Load) begin
                    word_d  = DatIn;
                    cnt_d   = neff;
                    state_d = (neff != '0) ? SEND : FNH;
                end
            end
            SEND: begin
                if (RdyOut && cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = FNH;
                end
            end
            FNH:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Remaining count N presents lane N-1; lane 0 is the final element
        lane       = LANE_W'(cnt_d - CNT_W'(1));
        val_d      = (state_d == SEND);
        done_d     = (state_d == FNH);
        rdy_load_d = (state_d == IDLE);
        last_d     = (state_d == SEND) && (cnt_d == CNT_W'(1));
        if (state_d == SEND) dat_d = word_d[lane*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            word_q     <= '0;
            dat_q      <= '0;
            val_q      <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            rdy_load_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            dat_q      <= dat_d;
            val_q      <= val_d;
            last_q     <= last_d;
            done_q     <= done_d;
            rdy_load_q <= rdy_load_d;
        end
    end

    assign RdyLoad = rdy_load_q;
    assign ValOut  = val_q;
    assign DatOut  = dat_q;
    assign LastOut = last_q;
    assign Done    = done_q;

endmodule

// File: tb/tb_unpacker.sv
// Randomized bench for unpacker: each word's expected element stream is built as a
// queue straight from the lane ordering rule and drained on observed transfers.
module tb_unpacker;

    localparam int unsigned ND = 32;
    localparam int unsigned DW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              Load;
    logic [5:0]        NumUnpack;
    logic [ND*DW-1:0]  DatIn;
    logic              RdyLoad;
    logic              ValOut;
    logic              RdyOut;
    logic [DW-1:0]     DatOut;
    logic              LastOut;
    logic              Done;

    int checks   = 0;
    int failures = 0;

    unpacker #(.NUM_DATA(ND), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Load      (Load),
        .NumUnpack (NumUnpack),
        .DatIn     (DatIn),
        .RdyLoad   (RdyLoad),
        .ValOut    (ValOut),
        .RdyOut    (RdyOut),
        .DatOut    (DatOut),
        .LastOut   (LastOut),
        .Done      (Done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ND*DW-1:0] rand_word();
        logic [ND*DW-1:0] w;
        for (int i = 0; i < ND; i++) w[i*DW +: DW] = DW'($urandom);
        return w;
    endfunction

    // One full word: load, stream with random backpressure, expect Done then idle.
    task automatic run_word(input logic [ND*DW-1:0] word, input int n, input int rdy_pct,
                            input bit poke);
        logic [DW-1:0] q[$];
        logic [DW-1:0] el;
        int neff;
        int xfers;
        int cyc;
        neff = (n > ND) ? ND : n;
        for (int j = neff - 1; j >= 0; j--) begin
            el = word[j*DW +: DW];
            q.push_back(el);
        end
        check("rdy_load_pre", 32'(RdyLoad), 32'd1);
        Load = 1'b1; NumUnpack = 6'(n); DatIn = word;
        tick();
        Load = 1'b0;
        xfers = 0;
        cyc = 0;
        while (q.size() > 0 && cyc < 400) begin
            check("val", 32'(ValOut), 32'd1);
            check("dat", 32'(DatOut), 32'(q[0]));
            check("last", 32'(LastOut), 32'(q.size() == 1));
            check("done_in_send", 32'(Done), 32'd0);
            check("rdy_load_in_send", 32'(RdyLoad), 32'd0);
            RdyOut = ($urandom_range(99) < rdy_pct);
            if (poke) begin
                Load = 1'($urandom_range(1));
                NumUnpack = 6'($urandom_range(40));
                DatIn = rand_word();
            end
            tick();
            if (RdyOut) begin
                el = q.pop_front();
                xfers++;
            end
            cyc++;
        end
        Load = 1'b0;
        RdyOut = 1'($urandom_range(1));
        check("xfers", 32'(xfers), 32'(neff));
        check("fnh_val", 32'(ValOut), 32'd0);
        check("fnh_last", 32'(LastOut), 32'd0);
        check("fnh_done", 32'(Done), 32'd1);
        check("fnh_rdy_load", 32'(RdyLoad), 32'd0);
        tick();
        check("idle_done", 32'(Done), 32'd0);
        check("idle_val", 32'(ValOut), 32'd0);
        check("idle_rdy_load", 32'(RdyLoad), 32'd1);
    endtask

    initial begin
        logic [ND*DW-1:0] w;
        logic [ND*DW-1:0] d;
        rst_n = 1'b0; Load = 1'b0; NumUnpack = '0; DatIn = '0; RdyOut = 1'b0;
        tick();
        Load = 1'b1; DatIn = rand_word(); NumUnpack = 6'd5;
        tick();
        check("rst_rdy_load", 32'(RdyLoad), 32'd1);
        check("rst_val", 32'(ValOut), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_last", 32'(LastOut), 32'd0);
        check("rst_dat", 32'(DatOut), 32'd0);
        Load = 1'b0;
        rst_n = 1'b1;
        tick();
        check("rst_load_ignored", 32'(ValOut), 32'd0);

        // Directed four-element word
        w = '0;
        w[31:0] = 32'h1122_3344;
        run_word(w, 4, 100, 1'b0);

        // Full word, 50% backpressure
        for (int r = 0; r < 2; r++) run_word(rand_word(), 32, 50, 1'b0);

        // Empty word goes straight to Done
        run_word(rand_word(), 0, 100, 1'b0);

        // Oversized count clamps; extra Loads during SEND are ignored
        run_word(rand_word(), 40, 60, 1'b1);

        // Random counts
        for (int r = 0; r < 6; r++) run_word(rand_word(), $urandom_range(40), 70, 1'b1);

        // Reset after the 2nd of 8 transfers, then a 2-element word
        w = rand_word();
        Load = 1'b1; NumUnpack = 6'd8; DatIn = w; RdyOut = 1'b1;
        tick();
        Load = 1'b0;
        check("pre_rst_dat0", 32'(DatOut), 32'(w[7*DW +: DW]));
        tick();
        check("pre_rst_dat1", 32'(DatOut), 32'(w[6*DW +: DW]));
        tick();
        rst_n = 1'b0; Load = 1'b1; NumUnpack = 6'd3;
        tick();
        check("mid_rst_val", 32'(ValOut), 32'd0);
        check("mid_rst_rdy_load", 32'(RdyLoad), 32'd1);
        check("mid_rst_done", 32'(Done), 32'd0);
        check("mid_rst_dat", 32'(DatOut), 32'd0);
        rst_n = 1'b1; Load = 1'b0;
        tick();
        check("post_rst_done", 32'(Done), 32'd0);
        check("post_rst_val", 32'(ValOut), 32'd0);
        run_word(rand_word(), 2, 100, 1'b0);

        // Back-to-back single-element words with Load held high
        RdyOut = 1'b1; Load = 1'b1; NumUnpack = 6'd1;
        d = rand_word();
        DatIn = d;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("b2b_val", 32'(ValOut), 32'd1);
            check("b2b_dat", 32'(DatOut), 32'(d[DW-1:0]));
            check("b2b_last", 32'(LastOut), 32'd1);
            DatIn = rand_word();
            tick();
            check("b2b_done", 32'(Done), 32'd1);
            check("b2b_fnh_val", 32'(ValOut), 32'd0);
            DatIn = rand_word();
            tick();
            check("b2b_idle", 32'(RdyLoad), 32'd1);
            check("b2b_idle_done", 32'(Done), 32'd0);
            d = rand_word();
            DatIn = d;
        end
        Load = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
